// File: rtl/kronos_types.sv
// Shared Kronos pipeline types: hazard-tracking slot record and RAW match helper.
package kronos_types;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       wr;
  } hcu_slot_t;

  localparam hcu_slot_t HCU_SLOT_NONE = hcu_slot_t'(7'd0);

  // x0 is never a dependency, and only valid, writing slots can produce a hazard
  function automatic logic raw_match(hcu_slot_t slot, logic [4:0] rs, logic rs_read);
    return rs_read & (rs != 5'd0) & slot.vld & slot.wr & (slot.rd == rs);
  endfunction

endpackage

// File: rtl/kronos_hcu_if.sv
// ID/EX/WB handshake and hazard signals exchanged between the pipeline and the HCU.
interface kronos_hcu_if;
  logic       id_vld;
  logic       id_rdy;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_read;
  logic       id_rs2_read;
  logic [4:0] id_rd;
  logic       id_rd_write;
  logic       ex_in_vld;
  logic       ex_in_rdy;
  logic       ex_out_vld;
  logic       ex_out_rdy;
  logic       wb_retire;
  logic       fwd_rs1;
  logic       fwd_rs2;
  logic       stall;

  modport master (
    output id_vld, id_rs1, id_rs2, id_rs1_read, id_rs2_read, id_rd, id_rd_write,
    output ex_in_rdy, ex_out_vld, ex_out_rdy, wb_retire,
    input  id_rdy, ex_in_vld, fwd_rs1, fwd_rs2, stall
  );

  modport slave (
    input  id_vld, id_rs1, id_rs2, id_rs1_read, id_rs2_read, id_rd, id_rd_write,
    input  ex_in_rdy, ex_out_vld, ex_out_rdy, wb_retire,
    output id_rdy, ex_in_vld, fwd_rs1, fwd_rs2, stall
  );
endinterface

// File: rtl/kronos_hcu.sv
// Kronos hazard control unit: holds ID on a RAW hazard against EX and selects
// WB forwarding when WB holds the only pending producer of an operand.
module kronos_hcu
  import kronos_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstz,
  kronos_hcu_if.slave      hcu,
  output logic [CNT_W-1:0] stall_cnt
);

  hcu_slot_t        ex_slot_r;
  hcu_slot_t        wb_slot_r;
  hcu_slot_t        id_slot_s;
  logic             rs1_ex_s;
  logic             rs2_ex_s;
  logic             rs1_wb_s;
  logic             rs2_wb_s;
  logic             stall_s;
  logic             xfer_s;
  logic             issue_s;
  logic [CNT_W-1:0] stall_cnt_r;

  // Classify each operand against the slots; stall never looks at ex_in_rdy
  always_comb begin
    rs1_ex_s      = raw_match(ex_slot_r, hcu.id_rs1, hcu.id_rs1_read);
    rs2_ex_s      = raw_match(ex_slot_r, hcu.id_rs2, hcu.id_rs2_read);
    rs1_wb_s      = raw_match(wb_slot_r, hcu.id_rs1, hcu.id_rs1_read);
    rs2_wb_s      = raw_match(wb_slot_r, hcu.id_rs2, hcu.id_rs2_read);
    stall_s       = rs1_ex_s | rs2_ex_s;
    xfer_s        = hcu.ex_out_vld & hcu.ex_out_rdy;
    issue_s       = hcu.id_vld & hcu.ex_in_rdy & ~stall_s;
    id_slot_s.vld = 1'b1;
    id_slot_s.rd  = hcu.id_rd;
    id_slot_s.wr  = hcu.id_rd_write & (hcu.id_rd != 5'd0);
  end

  assign hcu.stall     = stall_s;
  assign hcu.fwd_rs1   = ~rs1_ex_s & rs1_wb_s;
  assign hcu.fwd_rs2   = ~rs2_ex_s & rs2_wb_s;
  assign hcu.ex_in_vld = hcu.id_vld & ~stall_s;
  assign hcu.id_rdy    = hcu.ex_in_rdy & ~stall_s;
  assign stall_cnt     = stall_cnt_r;

  // WB slot: a transfer overwrites it even when the old WB entry retires
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      wb_slot_r <= HCU_SLOT_NONE;
    end else if (xfer_s) begin
      wb_slot_r <= ex_slot_r;
    end else if (hcu.wb_retire) begin
      wb_slot_r <= HCU_SLOT_NONE;
    end
  end

  // EX slot: a new issue wins over the departing instruction
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      ex_slot_r <= HCU_SLOT_NONE;
    end else if (issue_s) begin
      ex_slot_r <= id_slot_s;
    end else if (xfer_s) begin
      ex_slot_r <= HCU_SLOT_NONE;
    end
  end

  // Saturating count of cycles in which a valid ID instruction is held
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (hcu.id_vld && stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_kronos_hcu.sv
// Self-checking bench for kronos_hcu: directed hazard scenarios and random traffic
// compared every cycle against an in-flight producer list model.
module tb_kronos_hcu;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk  = 1'b0;
  logic             rstz = 1'b1;
  logic [CNT_W-1:0] stall_cnt;

  kronos_hcu_if bus ();

  kronos_hcu #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rstz      (rstz),
    .hcu       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // In-flight writers, oldest first; rd is 0 when the instruction writes nothing
  typedef struct {
    logic [4:0] rd;
    bit         in_ex;
  } ent_t;

  ent_t inflight[$];
  int   m_cnt  = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   chk_en = 1'b0;

  // 0: no pending producer, 1: youngest producer is in WB, 2: youngest is in EX
  function automatic int producer(logic [4:0] rs, logic rd_en);
    if (!rd_en || rs == 5'd0) return 0;
    for (int i = inflight.size() - 1; i >= 0; i--)
      if (inflight[i].rd == rs) return inflight[i].in_ex ? 2 : 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    return producer(bus.id_rs1, bus.id_rs1_read) == 2 ||
           producer(bus.id_rs2, bus.id_rs2_read) == 2;
  endfunction

  function automatic bit model_has_wb();
    foreach (inflight[i]) if (!inflight[i].in_ex) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall",     32'(bus.stall),     32'(exp_stall()));
      check("fwd_rs1",   32'(bus.fwd_rs1),   32'(producer(bus.id_rs1, bus.id_rs1_read) == 1));
      check("fwd_rs2",   32'(bus.fwd_rs2),   32'(producer(bus.id_rs2, bus.id_rs2_read) == 1));
      check("ex_in_vld", 32'(bus.ex_in_vld), 32'(bus.id_vld && !exp_stall()));
      check("id_rdy",    32'(bus.id_rdy),    32'(bus.ex_in_rdy && !exp_stall()));
      check("stall_cnt", 32'(stall_cnt),     32'(m_cnt));
    end
  end

  // Advance one clock edge with the current inputs, updating the model alongside
  task automatic step();
    bit   st;
    bit   issue;
    bit   xfer;
    ent_t nq[$];
    ent_t e;
    int   cnt_n;
    st    = exp_stall();
    issue = bus.id_vld && bus.ex_in_rdy && !st;
    xfer  = bus.ex_out_vld && bus.ex_out_rdy;
    cnt_n = m_cnt;
    if (rstz) begin
      if (xfer) check("wb_protocol", 32'(model_has_wb() && !bus.wb_retire), 32'd0);
      foreach (inflight[i]) begin
        if (inflight[i].in_ex) begin
          if (xfer) begin
            e.rd = inflight[i].rd; e.in_ex = 1'b0; nq.push_back(e);
          end else if (!issue) begin
            nq.push_back(inflight[i]);
          end
        end else if (!xfer && !bus.wb_retire) begin
          nq.push_back(inflight[i]);
        end
      end
      if (issue) begin
        e.rd    = (bus.id_rd_write && bus.id_rd != 5'd0) ? bus.id_rd : 5'd0;
        e.in_ex = 1'b1;
        nq.push_back(e);
      end
      if (bus.id_vld && st && cnt_n < CNT_MAX) cnt_n++;
    end
    @(posedge clk);
    if (rstz) begin
      inflight = nq;
      m_cnt    = cnt_n;
    end
    #1;
  endtask

  task automatic set_id(bit vld, int rs1, bit r1, int rs2, bit r2, int rd, bit w);
    bus.id_vld      = vld;
    bus.id_rs1      = 5'(rs1);
    bus.id_rs1_read = r1;
    bus.id_rs2      = 5'(rs2);
    bus.id_rs2_read = r2;
    bus.id_rd       = 5'(rd);
    bus.id_rd_write = w;
  endtask

  task automatic assert_reset();
    rstz = 1'b0;
    inflight.delete();
    m_cnt = 0;
  endtask

  task automatic drain();
    bus.id_vld = 1'b0;
    bus.ex_out_vld = 1'b1; bus.ex_out_rdy = 1'b1; bus.wb_retire = 1'b1;
    step(); step();
  endtask

  initial begin
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    bus.ex_in_rdy = 1'b1; bus.ex_out_vld = 1'b0; bus.ex_out_rdy = 1'b0; bus.wb_retire = 1'b0;
    #2;
    assert_reset();
    bus.id_vld = 1'b1;
    #1;
    chk_en = 1'b1;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_ex_in_vld", 32'(bus.ex_in_vld), 32'd1);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    step(); step();
    rstz = 1'b1;

    // Independent stream
    bus.ex_out_vld = 1'b1; bus.ex_out_rdy = 1'b1; bus.wb_retire = 1'b1;
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1); #1;
    check("ind_stall0", 32'(bus.stall), 32'd0);
    step();
    set_id(1'b1, 5, 1'b1, 6, 1'b1, 4, 1'b1); #1;
    check("ind_stall1", 32'(bus.stall), 32'd0);
    check("ind_fwd", 32'({bus.fwd_rs1, bus.fwd_rs2}), 32'd0);
    step();
    bus.id_vld = 1'b0;
    step(); step();
    check("ind_cnt", 32'(stall_cnt), 32'd0);

    // RAW against EX, then forward from WB
    bus.ex_out_vld = 1'b0;
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1); step();
    set_id(1'b1, 7, 1'b1, 0, 1'b0, 12, 1'b1); #1;
    check("raw_stall", 32'(bus.stall), 32'd1);
    check("raw_id_rdy", 32'(bus.id_rdy), 32'd0);
    check("raw_ex_in_vld", 32'(bus.ex_in_vld), 32'd0);
    step();
    bus.ex_out_vld = 1'b1; #1;
    check("raw_stall_hold", 32'(bus.stall), 32'd1);
    step();
    bus.ex_out_vld = 1'b0; #1;
    check("raw_after_stall", 32'(bus.stall), 32'd0);
    check("raw_fwd_rs1", 32'(bus.fwd_rs1), 32'd1);
    check("raw_issue_rdy", 32'(bus.id_rdy), 32'd1);
    step();
    set_id(1'b1, 12, 1'b1, 0, 1'b0, 0, 1'b0); #1;
    check("raw_consumer_in_ex", 32'(bus.stall), 32'd1);
    drain();

    // x0 destination and non-writing producer
    bus.ex_out_vld = 1'b0;
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1); step();
    set_id(1'b1, 0, 1'b1, 0, 1'b1, 13, 1'b0); #1;
    check("x0_stall", 32'(bus.stall), 32'd0);
    check("x0_fwd", 32'({bus.fwd_rs1, bus.fwd_rs2}), 32'd0);
    step();
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 8, 1'b0); step();
    set_id(1'b1, 8, 1'b1, 8, 1'b1, 0, 1'b0); #1;
    check("nowr_stall", 32'(bus.stall), 32'd0);
    drain();

    // Both slots write x9; retire and transfer together
    bus.ex_out_vld = 1'b0;
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1); step();
    bus.ex_out_vld = 1'b1; bus.wb_retire = 1'b0; step();
    bus.ex_out_vld = 1'b0;
    set_id(1'b1, 9, 1'b1, 9, 1'b1, 14, 1'b1); #1;
    check("x9_stall", 32'(bus.stall), 32'd1);
    bus.ex_out_vld = 1'b1; bus.wb_retire = 1'b1; step();
    bus.ex_out_vld = 1'b0; bus.wb_retire = 1'b0; #1;
    check("x9_stall_clear", 32'(bus.stall), 32'd0);
    check("x9_fwd_both", 32'({bus.fwd_rs1, bus.fwd_rs2}), 32'd3);
    drain();

    // Counter saturation
    bus.ex_out_vld = 1'b0;
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 10, 1'b1); step();
    set_id(1'b1, 0, 1'b0, 10, 1'b1, 15, 1'b1);
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt", 32'(stall_cnt), 32'd15);
    check("sat_stall", 32'(bus.stall), 32'd1);

    // Reset in the middle of a stall
    bus.id_vld = 1'b0;
    assert_reset(); step();
    rstz = 1'b1;
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 11, 1'b1); step();
    set_id(1'b1, 11, 1'b1, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    check("mid_cnt5", 32'(stall_cnt), 32'd5);
    check("mid_stall", 32'(bus.stall), 32'd1);
    assert_reset(); #1;
    check("mid_rst_stall", 32'(bus.stall), 32'd0);
    check("mid_rst_cnt", 32'(stall_cnt), 32'd0);
    check("mid_rst_ex_in_vld", 32'(bus.ex_in_vld), 32'd1);
    step();
    rstz = 1'b1; #1;
    check("post_rst_stall", 32'(bus.stall), 32'd0);
    check("post_rst_fwd", 32'(bus.fwd_rs1), 32'd0);

    // Random traffic over a small register set to provoke hazards
    for (int c = 0; c < 600; c++) begin
      set_id($urandom_range(0, 3) != 0,
             int'($urandom_range(0, 4)), $urandom_range(0, 3) != 0,
             int'($urandom_range(0, 4)), $urandom_range(0, 1) != 0,
             int'($urandom_range(0, 4)), $urandom_range(0, 3) != 0);
      bus.ex_in_rdy  = $urandom_range(0, 3) != 0;
      bus.ex_out_vld = $urandom_range(0, 1) != 0;
      bus.ex_out_rdy = $urandom_range(0, 3) != 0;
      bus.wb_retire  = $urandom_range(0, 1) != 0;
      if (bus.ex_out_vld && bus.ex_out_rdy && model_has_wb()) bus.wb_retire = 1'b1;
      step();
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
